// File: rtl/uart_rx_stream.sv
// UART receive path: 2-flop synchroniser, oversampled frame FSM, byte-to-word packing, valid/ready output.
// Optional partial-word idle timeout is compiled in with `define UART_RX_TIMEOUT_EN (adds TIMEOUT_BITS).
module uart_rx_stream #(
    parameter int CLK_DIV        = 27,
    parameter int OVERSAMPLE     = 16,
    parameter int D_BIT          = 8,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_MODE    = 0,
    parameter int BYTES_PER_WORD = 2
`ifdef UART_RX_TIMEOUT_EN
    , parameter int TIMEOUT_BITS = 4
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [8*BYTES_PER_WORD-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    output logic                          busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(BYTES_PER_WORD + 1);
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    // IDLE: wait for line low | START: confirm start at bit centre | DATA: shift bits LSB first
    // PARITY: check parity bit | STOP: check stop bit(s), then hand byte to packer
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             r_state, w_state_n;
    logic               r_rx_meta, r_rx_sync;
    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    logic [SCNT_W-1:0]  r_scnt, w_scnt_n;
    logic [3:0]         r_ncnt, w_ncnt_n;
    logic [D_BIT-1:0]   r_sh, w_sh_n;
    logic               r_ferr, w_ferr_n;
    logic               r_perr, w_perr_n;
    logic               r_done, w_done_n;
    logic               w_par_exp;
    logic [7:0]         w_byte;
    logic [WORD_W-1:0]  r_word, w_word_new;
    logic [BCNT_W-1:0]  r_bcnt;
    logic               w_to_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + DIV_W'(1);
    end
    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    assign w_par_exp = (PARITY_MODE == 2) ? ~(^r_sh) : (^r_sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_ncnt  <= '0;
            r_sh    <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_scnt  <= w_scnt_n;
            r_ncnt  <= w_ncnt_n;
            r_sh    <= w_sh_n;
            r_ferr  <= w_ferr_n;
            r_perr  <= w_perr_n;
            r_done  <= w_done_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_scnt_n  = r_scnt;
        w_ncnt_n  = r_ncnt;
        w_sh_n    = r_sh;
        w_ferr_n  = r_ferr;
        w_perr_n  = r_perr;
        w_done_n  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!r_rx_sync) begin
                    w_state_n = START;
                    w_scnt_n  = '0;
                    w_ferr_n  = 1'b0;
                    w_perr_n  = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_scnt == SCNT_W'(OVERSAMPLE/2 - 1)) begin
                        w_scnt_n  = '0;
                        w_ncnt_n  = '0;
                        w_state_n = r_rx_sync ? IDLE : DATA;
                    end else begin
                        w_scnt_n = r_scnt + SCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_scnt == SCNT_W'(OVERSAMPLE - 1)) begin
                        w_scnt_n = '0;
                        w_sh_n   = {r_rx_sync, r_sh[D_BIT-1:1]};
                        if (r_ncnt == 4'(D_BIT - 1)) begin
                            w_ncnt_n  = '0;
                            w_state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            w_ncnt_n = r_ncnt + 4'd1;
                        end
                    end else begin
                        w_scnt_n = r_scnt + SCNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    if (r_scnt == SCNT_W'(OVERSAMPLE - 1)) begin
                        w_scnt_n  = '0;
                        w_perr_n  = (r_rx_sync != w_par_exp);
                        w_state_n = STOP;
                    end else begin
                        w_scnt_n = r_scnt + SCNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_scnt == SCNT_W'(OVERSAMPLE - 1)) begin
                        w_scnt_n = '0;
                        if (!r_rx_sync)
                            w_ferr_n = 1'b1;
                        if (r_ncnt == 4'(STOP_BITS - 1)) begin
                            w_ncnt_n  = '0;
                            w_state_n = IDLE;
                            w_done_n  = 1'b1;
                        end else begin
                            w_ncnt_n = r_ncnt + 4'd1;
                        end
                    end else begin
                        w_scnt_n = r_scnt + SCNT_W'(1);
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    always_comb begin
        w_byte = '0;
        w_byte[D_BIT-1:0] = r_sh;
    end
    // Earlier bytes migrate toward the MSB as each new byte enters at the bottom.
    assign w_word_new = (r_word << 8) | WORD_W'(w_byte);

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W     = $clog2(TO_TICKS + 1);
    logic [TO_W-1:0] r_to;

    assign w_to_fire = w_tick && (r_state == IDLE) && (r_bcnt != '0) &&
                       (r_to == TO_W'(TO_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to <= '0;
        else if (r_state != IDLE || r_bcnt == '0)
            r_to <= '0;
        else if (w_tick && !w_to_fire)
            r_to <= r_to + TO_W'(1);
    end
`else
    assign w_to_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            r_word      <= '0;
            r_bcnt      <= '0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (r_done) begin
                if (r_ferr || r_perr) begin
                    frame_err  <= r_ferr;
                    parity_err <= r_perr;
                    r_word     <= '0;
                    r_bcnt     <= '0;
                end else if (r_bcnt == BCNT_W'(BYTES_PER_WORD - 1)) begin
                    r_word <= '0;
                    r_bcnt <= '0;
                    if (!out_valid || out_ready) begin
                        out_data  <= w_word_new;
                        out_valid <= 1'b1;
                    end else begin
                        overrun_err <= 1'b1;
                    end
                end else begin
                    r_word <= w_word_new;
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
            end else if (w_to_fire) begin
                r_word    <= '0;
                r_bcnt    <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream: one no-parity and one even-parity instance on separate lines.
module tb_uart_rx_stream;

    localparam int CLK_DIV = 4;
    localparam int OS      = 16;
    localparam int BIT     = CLK_DIV * OS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx0 = 1'b1;
    logic        rxp = 1'b1;
    logic        out_ready = 1'b1;

    logic [15:0] out_data0, out_datap;
    logic        out_valid0, out_validp;
    logic        frame_err0, parity_err0, overrun_err0, busy0;
    logic        frame_errp, parity_errp, overrun_errp, busyp;

    int n_cmp = 0;
    int n_mis = 0;
    int fe0 = 0, pe0 = 0, ov0 = 0;
    int fep = 0, pep = 0, ovp = 0;
    logic [15:0] q0[$];
    logic [15:0] qp[$];
    logic [15:0] exp0, expp;

    always #5 clk = ~clk;

    uart_rx_stream #(
        .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .D_BIT(8), .STOP_BITS(1),
        .PARITY_MODE(0), .BYTES_PER_WORD(2)
`ifdef UART_RX_TIMEOUT_EN
        , .TIMEOUT_BITS(4)
`endif
    ) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .frame_err(frame_err0), .parity_err(parity_err0), .overrun_err(overrun_err0),
        .busy(busy0)
    );

    uart_rx_stream #(
        .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .D_BIT(8), .STOP_BITS(1),
        .PARITY_MODE(1), .BYTES_PER_WORD(2)
`ifdef UART_RX_TIMEOUT_EN
        , .TIMEOUT_BITS(4)
`endif
    ) u_dutp (
        .clk(clk), .rst(rst), .rx(rxp),
        .out_data(out_datap), .out_valid(out_validp), .out_ready(out_ready),
        .frame_err(frame_errp), .parity_err(parity_errp), .overrun_err(overrun_errp),
        .busy(busyp)
    );

    // Monitors: count error pulses and check every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err0)   fe0++;
            if (parity_err0)  pe0++;
            if (overrun_err0) ov0++;
            if (out_valid0 && out_ready) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_mis++;
                    $display("FAIL word0_unexpected: got %04h, no word expected", out_data0);
                end else begin
                    exp0 = q0.pop_front();
                    if (out_data0 !== exp0) begin
                        n_mis++;
                        $display("FAIL word0: got %04h expected %04h", out_data0, exp0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_errp)   fep++;
            if (parity_errp)  pep++;
            if (overrun_errp) ovp++;
            if (out_validp && out_ready) begin
                n_cmp++;
                if (qp.size() == 0) begin
                    n_mis++;
                    $display("FAIL wordp_unexpected: got %04h, no word expected", out_datap);
                end else begin
                    expp = qp.pop_front();
                    if (out_datap !== expp) begin
                        n_mis++;
                        $display("FAIL wordp: got %04h expected %04h", out_datap, expp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int clocks);
        if (sel) rxp = v; else rx0 = v;
        repeat (clocks) @(negedge clk);
    endtask

    // A low stop bit is released after 3/4 bit so the trailing low is not taken as a new start.
    task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                        input bit par, input bit stop);
        drive(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT);
        if (par_en) drive(sel, par, BIT);
        if (stop) begin
            drive(sel, 1'b1, BIT);
        end else begin
            drive(sel, 1'b0, (3 * BIT) / 4);
            drive(sel, 1'b1, BIT / 4);
        end
        drive(sel, 1'b1, 0);
    endtask

    task automatic drain(input bit sel, input string nm);
        int k = 0;
        while (((sel ? qp.size() : q0.size()) != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(nm, sel ? qp.size() : q0.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_valid0", out_valid0, 0);
        chk("rst_data0", out_data0, 0);
        chk("rst_errs0", {frame_err0, parity_err0, overrun_err0, busy0}, 0);
        chk("rst_validp", out_validp, 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Basic word, consumer always ready
        q0.push_back(16'hA53C);
        send(0, 8'hA5, 0, 0, 1);
        send(0, 8'h3C, 0, 0, 1);
        drain(0, "basic_drain");
        chk("basic_errs", fe0 + pe0 + ov0, 0);

        // Overrun with consumer stalled
        out_ready = 1'b0;
        q0.push_back(16'h1234);
        send(0, 8'h12, 0, 0, 1);
        send(0, 8'h34, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("hold_valid", out_valid0, 1);
        chk("hold_data", out_data0, 16'h1234);
        send(0, 8'h56, 0, 0, 1);
        send(0, 8'h78, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("overrun_cnt", ov0, 1);
        chk("overrun_data", out_data0, 16'h1234);
        chk("overrun_valid", out_valid0, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_drop", out_valid0, 0);
        chk("accept_q", q0.size(), 0);

        // Parity: wrong parity on 0x07, then good 0x11, 0x22
        send(1, 8'h07, 1, 0, 1);
        repeat (4) @(negedge clk);
        chk("par_err_cnt", pep, 1);
        chk("par_no_word", out_validp, 0);
        chk("par_no_ferr", fep, 0);
        qp.push_back(16'h1122);
        send(1, 8'h11, 1, 0, 1);
        send(1, 8'h22, 1, 0, 1);
        drain(1, "par_drain");
        chk("par_err_final", pep, 1);

        // Frame error clears the partial word holding 0x55
        send(0, 8'h55, 0, 0, 1);
        send(0, 8'hFF, 0, 0, 0);
        repeat (BIT) @(negedge clk);
        chk("frame_cnt", fe0, 1);
        chk("frame_no_perr", pe0, 0);
        q0.push_back(16'hABCD);
        send(0, 8'hAB, 0, 0, 1);
        send(0, 8'hCD, 0, 0, 1);
        drain(0, "frame_drain");

        // Quarter-bit glitch while idle
        rx0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy", busy0, 1);
        repeat (BIT / 4 - 10) @(negedge clk);
        rx0 = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("glitch_idle", busy0, 0);
        chk("glitch_errs", {fe0[7:0], pe0[7:0], ov0[7:0]}, {8'd1, 8'd0, 8'd1});
        chk("glitch_no_word", out_valid0, 0);

        // Reset in the middle of DATA with a word pending
        out_ready = 1'b0;
        send(0, 8'h5A, 0, 0, 1);
        send(0, 8'hC3, 0, 0, 1);
        repeat (4) @(negedge clk);
        chk("pre_rst_data", out_data0, 16'h5AC3);
        drive(0, 1'b0, 3 * BIT);
        chk("pre_rst_busy", busy0, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid0, 0);
        chk("rst_mid_data", out_data0, 0);
        chk("rst_mid_busy", busy0, 0);
        rx0 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

`ifdef UART_RX_TIMEOUT_EN
        // Lone byte times out after 64 idle ticks
        send(0, 8'h99, 0, 0, 1);
        repeat (300) @(negedge clk);
        chk("timeout_ferr", fe0, 2);
        q0.push_back(16'h0102);
        send(0, 8'h01, 0, 0, 1);
        send(0, 8'h02, 0, 0, 1);
        drain(0, "timeout_drain");
`else
        // Without the timeout a lone byte waits indefinitely for its partner
        send(0, 8'h99, 0, 0, 1);
        repeat (300) @(negedge clk);
        chk("persist_no_ferr", fe0, 1);
        q0.push_back(16'h9901);
        send(0, 8'h01, 0, 0, 1);
        drain(0, "persist_drain");
`endif

        chk("final_ovp", ovp, 0);
        chk("final_q0", q0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
